fp32_adder_dual_acc_ctrl: RTL and testbench

- Sequencer for the dual-lane fp32 adder pipeline: compare stage, then align/add/normalise.
- Per output tile, runs a chain of num_terms additions on both lanes in lockstep.
  - The first addition adds the incoming operand to the bias (bias_mode=1).
  - Every later addition adds it to the running accumulator (bias_mode=0).
- Each term depends on the previous sum, so the controller stalls operand acceptance until the previous result has returned through the ADDER_LATENCY-cycle pipeline.
- Sits between the operand producer (valid/ready) and the adder plus accumulator register file.

---
 rtl/fp32_adder_dual_acc_ctrl.sv | 90 +++++++++
 tb/tb_fp32_adder_dual_acc_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fp32_adder_dual_acc_ctrl.sv
// fp32_adder_dual_acc_ctrl: per-tile add-chain sequencer (bias first, then accumulate), one term in flight.
// Define FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN to add tile_count/stall_count counters.
module fp32_adder_dual_acc_ctrl #(
  parameter int TERM_CNT_WIDTH = 8,
  parameter int ADDER_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [TERM_CNT_WIDTH-1:0] num_terms,
  input  logic b_valid,
  output logic b_ready,
  output logic bias_mode,
  output logic acc_we,
  output logic busy,
  output logic done
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] tile_count,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [TERM_CNT_WIDTH-1:0] num_q, num_d, term_q, term_d;
  logic [7:0] wait_q, wait_d;
  logic bias_q, bias_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      term_q <= '0;
      wait_q <= '0;
      bias_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      term_q <= term_d;
      wait_q <= wait_d;
      bias_q <= bias_d;
    end
  end
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    term_d = term_q;
    wait_d = wait_q;
    bias_d = bias_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = num_terms != '0 ? ISSUE : DONE;
        if (num_terms != '0) begin
          num_d = num_terms;
          term_d = '0;
          bias_d = 1'b1;
        end
      end
      ISSUE: if (b_valid) begin
        state_d = WAIT;
        term_d = term_q + TERM_CNT_WIDTH'(1);
        bias_d = 1'b0;
        wait_d = 8'(ADDER_LATENCY - 1);
      end
      WAIT: begin
        wait_d = wait_q != '0 ? wait_q - 8'd1 : wait_q;
        if (wait_q == '0) state_d = term_q == num_q ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Every output is a decode of registered state; nothing flows through from inputs.
  always_comb begin
    b_ready = state_q == ISSUE;
    busy = state_q != IDLE;
    done = state_q == DONE;
    acc_we = state_q == WAIT && wait_q == '0;
    bias_mode = bias_q;
  end
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_count <= '0;
      stall_count <= '0;
    end else begin
      tile_count <= tile_count + 32'(state_q == DONE);
      stall_count <= stall_count + 32'(state_q == ISSUE && !b_valid);
    end
  end
`endif
endmodule

// File: tb/tb_fp32_adder_dual_acc_ctrl.sv
// tb_fp32_adder_dual_acc_ctrl: scoreboard bench; expected fire/acc_we/done cycles queued per tile, popped as the DUT emits them.
module tb_fp32_adder_dual_acc_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, b_valid = 1'b0;
  logic [7:0] num_terms = '0;
  logic b_ready4, bias4, acc_we4, busy4, done4;
  logic b_ready1, bias1, acc_we1, busy1, done1;
  logic sel = 1'b0, act = 1'b0;
  int cyc = 0, t0 = 0, busy_hi = 0, rc = -1;
  int checks = 0, errors = 0;
  int exp_q[$];
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
  logic [31:0] tile4, stall4, tile1, stall1;
`endif
  fp32_adder_dual_acc_ctrl #(.TERM_CNT_WIDTH(8), .ADDER_LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .b_valid(b_valid),
    .b_ready(b_ready4), .bias_mode(bias4), .acc_we(acc_we4), .busy(busy4), .done(done4)
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
    , .tile_count(tile4), .stall_count(stall4)
`endif
  );
  fp32_adder_dual_acc_ctrl #(.TERM_CNT_WIDTH(8), .ADDER_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .b_valid(b_valid),
    .b_ready(b_ready1), .bias_mode(bias1), .acc_we(acc_we1), .busy(busy1), .done(done1)
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
    , .tile_count(tile1), .stall_count(stall1)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  wire b_ready_m = sel ? b_ready1 : b_ready4;
  wire bias_m = sel ? bias1 : bias4;
  wire acc_we_m = sel ? acc_we1 : acc_we4;
  wire busy_m = sel ? busy1 : busy4;
  wire done_m = sel ? done1 : done4;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask
  // Event code: 1 fire, 4 fire with bias_mode, 2 acc_we, 3 done; low 16 bits hold the tile-relative cycle.
  function automatic int ev(input int code, input int c);
    return (code << 16) | c;
  endfunction
  task automatic pop(input string tag, input int got);
    if (exp_q.size() == 0) check({tag, "_extra"}, got, -1);
    else check(tag, got, exp_q.pop_front());
  endtask
  always @(negedge clk) if (act) begin
    int rel;
    rel = cyc - t0;
    if (b_ready_m && b_valid) pop("fire", ev(bias_m ? 4 : 1, rel));
    if (acc_we_m) pop("acc_we", ev(2, rel));
    if (done_m) pop("done", ev(3, rel));
    check("busy", busy_m, int'(rel >= 1 && rel <= busy_hi));
    if (rc >= 0 && rel == rc + 1) check("post_rst", {b_ready_m, bias_m, acc_we_m, done_m, busy_m}, 0);
  end
  task automatic do_reset();
    act = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out4", {b_ready4, bias4, acc_we4, done4, busy4}, 0);
    check("rst_out1", {b_ready1, bias1, acc_we1, done1, busy1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  // Drives one tile for len cycles; sc pulses a stray start (num_terms=9), rcyc asserts rst for one cycle.
  task automatic run(input int nt, input int lo, input int hi, input int len, input int bh, input int sc, input int rcyc);
    @(posedge clk); #1;
    t0 = cyc;
    busy_hi = bh;
    rc = rcyc;
    act = 1'b1;
    start = 1'b1;
    num_terms = 8'(nt);
    b_valid = !(lo <= 0 && hi >= 0);
    for (int k = 1; k < len; k++) begin
      @(posedge clk); #1;
      start = k == sc;
      num_terms = k == sc ? 8'd9 : 8'(nt);
      b_valid = !(k >= lo && k <= hi);
      rst = k == rcyc;
    end
    @(negedge clk);
    check("pending", exp_q.size(), 0);
    exp_q.delete();
    start = 1'b0;
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    exp_q = '{ev(4, 1), ev(2, 5), ev(1, 6), ev(2, 10), ev(1, 11), ev(2, 15), ev(3, 16)};
    run(3, -1, -1, 18, 16, -1, -1);
    do_reset();
    exp_q = '{ev(4, 1), ev(2, 5), ev(1, 9), ev(2, 13), ev(1, 14), ev(2, 18), ev(3, 19)};
    run(3, 6, 8, 21, 19, -1, -1);
`ifdef FP32_ADDER_DUAL_ACC_CTRL_PERF_CNT_EN
    check("stall_count", stall4, 3);
    check("tile_count", tile4, 1);
`endif
    exp_q = '{ev(3, 1)};
    run(0, -1, -1, 3, 1, -1, -1);
    exp_q = '{ev(4, 1), ev(2, 5), ev(1, 6), ev(2, 10), ev(1, 11), ev(2, 15), ev(3, 16)};
    run(3, -1, -1, 18, 16, 7, -1);
    exp_q = '{ev(4, 1), ev(2, 5), ev(3, 6)};
    run(1, -1, -1, 8, 6, -1, -1);
    exp_q = '{ev(4, 1), ev(2, 5), ev(1, 6)};
    run(3, -1, -1, 10, 8, -1, 8);
    exp_q = '{ev(4, 1), ev(2, 5), ev(3, 6)};
    run(1, -1, -1, 8, 6, -1, -1);
    do_reset();
    sel = 1'b1;
    exp_q = '{ev(4, 1), ev(2, 2), ev(1, 3), ev(2, 4), ev(3, 5)};
    run(2, -1, -1, 7, 5, -1, -1);
    act = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
